// File: rtl/pipe_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : pipe_scheduler
// Purpose  : Owns NUM_PIPES scrolling pipe positions; once per frame it drives
//            pipe_drawer through erase -> move -> redraw and emits a score pulse.
// Revision : 1.0  initial release
// ============================================================================
module pipe_scheduler #(
  parameter int NUM_PIPES = 3,
  parameter int SPACING   = 220,
  parameter int SPEED     = 2,
  parameter int START_X   = 680,
  parameter int MIN_X     = 40,
  parameter int Y_BASE    = 180,
  parameter int RESET_Y   = 300,
  parameter int BIRD_X    = 160
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic        run,
  input  logic        draw_done,
  output logic        draw_enable,
  output logic [10:0] pipe_x,
  output logic [10:0] pipe_y,
  output logic        color,
  output logic        busy,
  output logic        frame_done,
  output logic        score_pulse
);

  localparam logic [1:0]  c_LAST     = 2'(NUM_PIPES - 1);
  localparam logic [10:0] c_WRAP_LIM = 11'(MIN_X + SPEED);
  localparam logic [10:0] c_SPEED    = 11'(SPEED);
  localparam logic [10:0] c_WRAP_ADD = 11'(NUM_PIPES * SPACING);
  localparam logic [10:0] c_Y_BASE   = 11'(Y_BASE);
  localparam logic [10:0] c_RESET_Y  = 11'(RESET_Y);
  localparam logic [10:0] c_BIRD_X   = 11'(BIRD_X);
  localparam logic [7:0]  c_SEED     = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ERASE_REQ  = 3'd1,
    S_ERASE_WAIT = 3'd2,
    S_MOVE       = 3'd3,
    S_DRAW_REQ   = 3'd4,
    S_DRAW_WAIT  = 3'd5,
    S_FIN        = 3'd6
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_idx, w_idx_nxt;
  logic [7:0]  r_lfsr, w_lfsr_nxt;
  logic [10:0] r_x [NUM_PIPES];
  logic [10:0] r_y [NUM_PIPES];
  logic [10:0] w_new_x [NUM_PIPES];
  logic [10:0] w_new_y [NUM_PIPES];
  logic        w_score;
  logic        w_req;
  logic [10:0] w_sel_x, w_sel_y;

  // Candidate positions for the MOVE cycle; only non-wrapping pipes can score.
  always_comb begin
    w_score = 1'b0;
    for (int i = 0; i < NUM_PIPES; i++) begin
      if (r_x[i] < c_WRAP_LIM) begin
        w_new_x[i] = r_x[i] - c_SPEED + c_WRAP_ADD;
        w_new_y[i] = c_Y_BASE + 11'(r_lfsr);
      end else begin
        w_new_x[i] = r_x[i] - c_SPEED;
        w_new_y[i] = r_y[i];
        if ((r_x[i] > c_BIRD_X) && (w_new_x[i] <= c_BIRD_X)) begin
          w_score = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_lfsr_nxt  = r_lfsr;
    case (r_state)
      S_IDLE: begin
        if (frame_start && run) begin
          w_idx_nxt   = 2'd0;
          w_lfsr_nxt  = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
          w_state_nxt = S_ERASE_REQ;
        end
      end
      S_ERASE_REQ: w_state_nxt = S_ERASE_WAIT;
      S_ERASE_WAIT: begin
        if (draw_done) begin
          if (r_idx == c_LAST) begin
            w_state_nxt = S_MOVE;
          end else begin
            w_idx_nxt   = r_idx + 2'd1;
            w_state_nxt = S_ERASE_REQ;
          end
        end
      end
      S_MOVE: begin
        w_idx_nxt   = 2'd0;
        w_state_nxt = S_DRAW_REQ;
      end
      S_DRAW_REQ: w_state_nxt = S_DRAW_WAIT;
      S_DRAW_WAIT: begin
        if (draw_done) begin
          if (r_idx == c_LAST) begin
            w_state_nxt = S_FIN;
          end else begin
            w_idx_nxt   = r_idx + 2'd1;
            w_state_nxt = S_DRAW_REQ;
          end
        end
      end
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_req = (w_state_nxt == S_ERASE_REQ) || (w_state_nxt == S_DRAW_REQ);

  // The first draw request follows MOVE directly, so it must see the new positions.
  always_comb begin
    w_sel_x = '0;
    w_sel_y = '0;
    for (int i = 0; i < NUM_PIPES; i++) begin
      if (w_idx_nxt == 2'(i)) begin
        w_sel_x = (r_state == S_MOVE) ? w_new_x[i] : r_x[i];
        w_sel_y = (r_state == S_MOVE) ? w_new_y[i] : r_y[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_idx   <= 2'd0;
      r_lfsr  <= c_SEED;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_lfsr  <= w_lfsr_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_PIPES; i++) begin
        r_x[i] <= 11'(START_X + i * SPACING);
        r_y[i] <= c_RESET_Y;
      end
    end else if (r_state == S_MOVE) begin
      for (int i = 0; i < NUM_PIPES; i++) begin
        r_x[i] <= w_new_x[i];
        r_y[i] <= w_new_y[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      draw_enable <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      score_pulse <= 1'b0;
      pipe_x      <= '0;
      pipe_y      <= '0;
      color       <= 1'b0;
    end else begin
      draw_enable <= w_req;
      busy        <= (w_state_nxt != S_IDLE);
      frame_done  <= (w_state_nxt == S_FIN);
      score_pulse <= (r_state == S_MOVE) && w_score;
      if (w_req) begin
        pipe_x <= w_sel_x;
        pipe_y <= w_sel_y;
        color  <= (w_state_nxt == S_DRAW_REQ);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_scheduler.sv
`default_nettype none
// Bench for pipe_scheduler: stub drawer answers 5 cycles after enable; a
// reference model fills a request queue that is drained on every draw_enable.
module tb_pipe_scheduler;

  localparam int NP = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        frame_start = 1'b0;
  logic        run = 1'b0;
  logic        draw_done = 1'b0;
  logic        draw_enable, color, busy, frame_done, score_pulse;
  logic [10:0] pipe_x, pipe_y;

  always #5 clk = ~clk;

  pipe_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .run         (run),
    .draw_done   (draw_done),
    .draw_enable (draw_enable),
    .pipe_x      (pipe_x),
    .pipe_y      (pipe_y),
    .color       (color),
    .busy        (busy),
    .frame_done  (frame_done),
    .score_pulse (score_pulse)
  );

  typedef struct {int x; int y; int c;} req_t;
  req_t q[$];
  req_t mon_e;

  int n_chk = 0, n_pass = 0;
  int n_en = 0, n_fd = 0, n_sc = 0, n_busy = 0;
  bit stub_on = 1'b1;
  int mx [NP];
  int my [NP];
  logic [7:0] mlfsr;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin
      mx[i] = 680 + i * 220;
      my[i] = 300;
    end
    mlfsr = 8'hA5;
  endtask

  // Pushes the six expected requests of one frame and returns the expected score count.
  task automatic build_frame(output int exp_sc);
    int nx;
    exp_sc = 0;
    mlfsr = lfsr_step(mlfsr);
    for (int i = 0; i < NP; i++) q.push_back('{x: mx[i], y: my[i], c: 0});
    for (int i = 0; i < NP; i++) begin
      if (mx[i] < 42) begin
        nx = mx[i] - 2 + 660;
        my[i] = 180 + int'(mlfsr);
      end else begin
        nx = mx[i] - 2;
        if (mx[i] > 160 && nx <= 160) exp_sc++;
      end
      mx[i] = nx;
    end
    for (int i = 0; i < NP; i++) q.push_back('{x: mx[i], y: my[i], c: 1});
  endtask

  // Stub drawer.
  initial begin
    forever begin
      @(negedge clk);
      if (draw_enable) begin
        repeat (5) @(posedge clk);
        #1 if (stub_on) draw_done = 1'b1;
        @(posedge clk);
        #1 draw_done = 1'b0;
      end
    end
  end

  // Output monitor and scoreboard drain.
  always @(negedge clk) begin
    if (busy) n_busy++;
    if (frame_done) n_fd++;
    if (score_pulse) n_sc++;
    if (draw_enable) begin
      n_en++;
      chk("req_expected", int'(q.size() != 0), 1);
      if (q.size() != 0) begin
        mon_e = q.pop_front();
        chk("req_x", int'(pipe_x), mon_e.x);
        chk("req_y", int'(pipe_y), mon_e.y);
        chk("req_color", int'(color), mon_e.c);
      end
    end
  end

  task automatic run_frame(input bit inject);
    int exp_sc;
    int cyc;
    build_frame(exp_sc);
    n_en = 0; n_fd = 0; n_sc = 0; n_busy = 0;
    @(posedge clk); #1 frame_start = 1'b1; run = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
    if (inject) begin
      repeat (2) @(posedge clk);
      #1 frame_start = 1'b1;
      @(posedge clk); #1 frame_start = 1'b0;
    end
    cyc = 0;
    while (n_fd == 0 && cyc < 400) begin
      @(posedge clk);
      cyc++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk("frame_done", n_fd, 1);
    chk("enables", n_en, 6);
    chk("score", n_sc, exp_sc);
    chk("busy_cycles", n_busy, 38);
    chk("busy_idle", int'(busy), 0);
    chk("q_drain", q.size(), 0);
    q.delete();
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_en"},    int'(draw_enable), 0);
    chk({pfx, "_busy"},  int'(busy), 0);
    chk({pfx, "_fdone"}, int'(frame_done), 0);
    chk({pfx, "_score"}, int'(score_pulse), 0);
    chk({pfx, "_x"},     int'(pipe_x), 0);
    chk({pfx, "_y"},     int'(pipe_y), 0);
    chk({pfx, "_color"}, int'(color), 0);
  endtask

  initial begin
    int cyc;
    int dummy;
    model_reset();
    repeat (3) @(posedge clk);
    #1 chk_reset_outputs("rst");
    reset = 1'b1;

    run_frame(1'b0);

    n_en = 0; n_busy = 0;
    @(posedge clk); #1 frame_start = 1'b1; run = 1'b0;
    @(posedge clk); #1 frame_start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("run0_en", n_en, 0);
    chk("run0_busy", n_busy, 0);

    for (int f = 2; f <= 321; f++) run_frame(f == 5);

    // Abort mid-frame during DRAW_WAIT of pipe 1.
    build_frame(dummy);
    void'(q.pop_back());
    n_en = 0;
    @(posedge clk); #1 frame_start = 1'b1; run = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
    cyc = 0;
    while (n_en < 5 && cyc < 400) begin
      @(posedge clk);
      cyc++;
    end
    chk("abort_reached", n_en, 5);
    repeat (2) @(posedge clk);
    #1 stub_on = 1'b0; reset = 1'b0;
    #2 chk_reset_outputs("abort");
    chk("abort_q", q.size(), 0);
    q.delete();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 draw_done = 1'b1;
    @(posedge clk); #1 draw_done = 1'b0;
    n_en = 0; n_busy = 0;
    repeat (8) @(posedge clk);
    #1;
    chk("late_done_en", n_en, 0);
    chk("late_done_busy", n_busy, 0);
    stub_on = 1'b1;
    model_reset();
    run_frame(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
